dct_1d_serial: RTL and testbench



---
 rtl/dct_pkg.sv | 36 +++
 rtl/dct_1d_serial.sv | 145 ++++++++++++++
 tb/tb_dct_1d_serial.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dct_pkg.sv
// Shared constants, coefficient ROM and FSM states for the serial DCT stage.
// Also used by the transpose buffer and the second DCT instance.
package dct_pkg;

  localparam int FRAC   = 12;
  localparam int COEF_W = 14;

  typedef logic signed [COEF_W-1:0] coef_t;

  typedef enum logic [1:0] {
    LOAD,
    MAC,
    OUT
  } state_t;

  // C[k][n] = round(2^FRAC * a(k) * cos((2n+1)k*pi/16))
  localparam coef_t C [8][8] = '{
    '{ 14'sd1448,  14'sd1448,  14'sd1448,  14'sd1448,
       14'sd1448,  14'sd1448,  14'sd1448,  14'sd1448 },
    '{ 14'sd2009,  14'sd1703,  14'sd1138,  14'sd400,
      -14'sd400,  -14'sd1138, -14'sd1703, -14'sd2009 },
    '{ 14'sd1892,  14'sd784,  -14'sd784,  -14'sd1892,
      -14'sd1892, -14'sd784,   14'sd784,   14'sd1892 },
    '{ 14'sd1703, -14'sd400,  -14'sd2009, -14'sd1138,
       14'sd1138,  14'sd2009,  14'sd400,  -14'sd1703 },
    '{ 14'sd1448, -14'sd1448, -14'sd1448,  14'sd1448,
       14'sd1448, -14'sd1448, -14'sd1448,  14'sd1448 },
    '{ 14'sd1138, -14'sd2009,  14'sd400,   14'sd1703,
      -14'sd1703, -14'sd400,   14'sd2009, -14'sd1138 },
    '{ 14'sd784,  -14'sd1892,  14'sd1892, -14'sd784,
      -14'sd784,   14'sd1892, -14'sd1892,  14'sd784 },
    '{ 14'sd400,  -14'sd1138,  14'sd1703, -14'sd2009,
       14'sd2009, -14'sd1703,  14'sd1138, -14'sd400 }
  };

endpackage

// File: rtl/dct_1d_serial.sv
// Serial 8-point DCT-II: one time-shared multiplier, coefficients X[0]..X[7].
// Optional DCT_SATURATE_EN clamps results; otherwise the low bits wrap.
module dct_1d_serial
  import dct_pkg::*;
#(
  parameter int IN_W  = 12,
  parameter int OUT_W = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena_in,
  output logic                    rdy_out,
  input  logic signed [IN_W-1:0]  S_in,
  output logic                    ena_out,
  input  logic                    rdy_in,
  output logic signed [OUT_W-1:0] S_out
);

  localparam int ACC_W = IN_W + COEF_W + 3;
  localparam logic signed [ACC_W-1:0] BIAS =
    ACC_W'(2 ** (FRAC - 1));

`ifdef DCT_SATURATE_EN
  localparam int RND_W = ACC_W - FRAC;
  localparam logic signed [RND_W-1:0] MAXV =
    RND_W'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [RND_W-1:0] MINV =
    -RND_W'(2 ** (OUT_W - 1));
  logic signed [RND_W-1:0] rnd;
`endif

  state_t state;
  state_t state_nxt;

  logic signed [IN_W-1:0]  x [8];
  logic [2:0]              idx;
  logic [2:0]              k;
  logic [2:0]              n;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] xe;
  logic signed [ACC_W-1:0] ce;
  logic signed [ACC_W-1:0] prod;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [OUT_W-1:0] res;
  logic                    xfer;
  logic                    take;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      (state == LOAD):
        if (xfer && idx == 3'd7) state_nxt = MAC;
      (state == MAC):
        if (n == 3'd7) state_nxt = OUT;
      (state == OUT):
        if (take)
          state_nxt = (k == 3'd7) ? LOAD : MAC;
      default:
        state_nxt = LOAD;
    endcase
  end

  // Handshake outputs and transfer strobes
  always_comb begin
    rdy_out = (state == LOAD) && !rst;
    xfer    = ena_in && rdy_out;
    take    = (state == OUT) && ena_out && rdy_in;
  end

  // Multiply-accumulate, half-up rounding and output range handling
  always_comb begin
    xe      = ACC_W'(x[n]);
    ce      = ACC_W'(C[k][n]);
    prod    = xe * ce;
    acc_sum = acc + prod;
`ifdef DCT_SATURATE_EN
    rnd = RND_W'((acc_sum + BIAS) >>> FRAC);
    if (rnd > MAXV)
      res = {1'b0, {(OUT_W-1){1'b1}}};
    else if (rnd < MINV)
      res = {1'b1, {(OUT_W-1){1'b0}}};
    else
      res = rnd[OUT_W-1:0];
`else
    res = OUT_W'((acc_sum + BIAS) >>> FRAC);
`endif
  end

  // Sample buffer; stale contents are harmless since idx restarts at 0
  always_ff @(posedge clk) begin
    if (!rst && xfer) x[idx] <= S_in;
  end

  // Indices, accumulator and registered coefficient output
  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= 3'd0;
      k       <= 3'd0;
      n       <= 3'd0;
      acc     <= '0;
      ena_out <= 1'b0;
      S_out   <= '0;
    end else begin
      unique case (1'b1)
        (state == LOAD): begin
          if (xfer) begin
            idx <= idx + 3'd1;
            if (idx == 3'd7) begin
              k   <= 3'd0;
              n   <= 3'd0;
              acc <= '0;
            end
          end
        end
        (state == MAC): begin
          acc <= acc_sum;
          n   <= n + 3'd1;
          if (n == 3'd7) begin
            S_out   <= res;
            ena_out <= 1'b1;
          end
        end
        (state == OUT): begin
          if (take) begin
            ena_out <= 1'b0;
            k       <= k + 3'd1;
            n       <= 3'd0;
            acc     <= '0;
          end
        end
        default: begin
          ena_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dct_1d_serial.sv
// Scoreboard bench for dct_1d_serial against a floating-point DCT-II model.
// Build with DCT_SATURATE_EN defined to check the clamping variant.
module tb_dct_1d_serial;

  localparam real PI = 3.14159265358979323846;

  typedef int vec_t [8];
  typedef struct {
    int v;
    int tol;
    int vid;
    int k;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic ena_in;
  logic rdy_out;
  logic signed [11:0] S_in;
  logic ena_out;
  logic rdy_in;
  logic signed [11:0] S_out;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;
  bit   bp_rand = 1'b0;

  dct_1d_serial #(
    .IN_W (12),
    .OUT_W(12)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .ena_in (ena_in),
    .rdy_out(rdy_out),
    .S_in   (S_in),
    .ena_out(ena_out),
    .rdy_in (rdy_in),
    .S_out  (S_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got,
                       input int exp, input int tol);
    tests++;
    if (got - exp > tol || exp - got > tol) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)",
               name, got, exp, tol);
    end
  endtask

  // Ideal orthonormal DCT-II, rounded, then clamped or wrapped to 12 bits
  task automatic model(input vec_t v, output vec_t X);
    for (int k = 0; k < 8; k++) begin
      real s;
      real a;
      int  r;
      logic signed [11:0] w;
      s = 0.0;
      for (int n = 0; n < 8; n++)
        s += real'(v[n]) * $cos(real'((2*n+1)*k) * PI / 16.0);
      a = (k == 0) ? $sqrt(0.125) : 0.5;
      r = $rtoi($floor(a * s + 0.5));
`ifdef DCT_SATURATE_EN
      if (r > 2047)  r = 2047;
      if (r < -2048) r = -2048;
`else
      w = r[11:0];
      r = int'(w);
`endif
      X[k] = r;
    end
  endtask

  task automatic push_vec(input vec_t X, input vec_t tl,
                          input int vid);
    for (int k = 0; k < 8; k++) begin
      exp_t e;
      e.v   = X[k];
      e.tol = tl[k];
      e.vid = vid;
      e.k   = k;
      sbq.push_back(e);
    end
  endtask

  // Called just after a rising edge; returns just after the edge
  // that captured the last requested sample.
  task automatic send_vec(input vec_t v, input int gap,
                          input int nsamp);
    for (int i = 0; i < nsamp; i++) begin
      bit ok;
      int t;
      ena_in = 1'b1;
      S_in   = 12'(v[i]);
      t = 0;
      do begin
        @(negedge clk);
        ok = rdy_out;
        @(posedge clk);
        #1;
        t++;
      end while (!ok && t < 3000);
      if (!ok) begin
        tests++;
        fails++;
        $display("FAIL send timeout: rdy_out low %0d cycles", t);
        ena_in = 1'b0;
        return;
      end
      if (gap > 0 && i < nsamp - 1) begin
        int g;
        g = $urandom_range(0, gap);
        if (g > 0) begin
          ena_in = 1'b0;
          S_in   = 12'($urandom);
          repeat (g) begin
            @(posedge clk);
            #1;
          end
        end
      end
    end
    ena_in = 1'b0;
    S_in   = 12'($urandom);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (sbq.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (sbq.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain timeout: %0d outputs missing",
               sbq.size());
      sbq.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ena(output bit seen);
    int t;
    t = 0;
    seen = 1'b0;
    while (!seen && t < 200) begin
      @(negedge clk);
      seen = ena_out;
      t++;
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL ena_out timeout after %0d cycles", t);
    end
  endtask

  // Random downstream backpressure when enabled
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_rand) rdy_in = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: every accepted coefficient is popped and compared
  always @(negedge clk) begin
    if (!rst && ena_out && rdy_in) begin
      check("rdy_out low while ena_out", int'(rdy_out), 0, 0);
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected output: got %0d, expected none",
                 int'(S_out));
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check($sformatf("vec%0d X%0d", e.vid, e.k),
              int'(S_out), e.v, e.tol);
      end
    end
  end

  initial begin
    vec_t v;
    vec_t X;
    vec_t tl;
    int   cnt;
    bit   seen;

    rst    = 1'b1;
    ena_in = 1'b0;
    S_in   = '0;
    rdy_in = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset rdy_out", int'(rdy_out), 0, 0);
    check("reset ena_out", int'(ena_out), 0, 0);
    check("reset S_out", int'(S_out), 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rdy_out after reset", int'(rdy_out), 1, 0);
    @(posedge clk);
    #1;

    // DC vector and first-output latency
    v = '{default: 100};
    model(v, X);
    tl = '{default: 1};
    X[0] = 283;
    tl[0] = 0;
    push_vec(X, tl, 0);
    send_vec(v, 0, 8);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!ena_out && cnt < 30);
    check("latency", cnt, 9, 0);
    wait_drain();

    // Impulse
    v = '{1000, 0, 0, 0, 0, 0, 0, 0};
    model(v, X);
    tl = '{default: 1};
    X[0] = 354;
    X[1] = 490;
    tl[0] = 0;
    tl[1] = 0;
    push_vec(X, tl, 1);
    send_vec(v, 0, 8);
    wait_drain();

    // Full-scale DC exceeds the output range
    v = '{default: 2047};
    model(v, X);
    tl = '{default: 1};
`ifdef DCT_SATURATE_EN
    X[0] = 2047;
`else
    X[0] = 1693;
`endif
    tl[0] = 0;
    push_vec(X, tl, 2);
    send_vec(v, 0, 8);
    wait_drain();

    // Backpressure on X[0] for 11 cycles
    v = '{-175, -125, -75, -25, 25, 75, 125, 175};
    model(v, X);
    tl = '{default: 1};
    rdy_in = 1'b0;
    push_vec(X, tl, 3);
    send_vec(v, 0, 8);
    wait_ena(seen);
    for (int i = 0; i < 11; i++) begin
      check("held S_out", int'(S_out), X[0], 1);
      check("held ena_out", int'(ena_out), 1, 0);
      check("held rdy_out", int'(rdy_out), 0, 0);
      if (i < 10) @(negedge clk);
    end
    @(posedge clk);
    #1;
    rdy_in = 1'b1;
    wait_drain();
    @(negedge clk);
    check("rdy_out after X7", int'(rdy_out), 1, 0);
    @(posedge clk);
    #1;

    // Reset after 5 samples discards the partial vector
    v = '{default: 555};
    send_vec(v, 0, 5);
    rst = 1'b1;
    @(negedge clk);
    check("rdy_out during rst", int'(rdy_out), 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid rst ena_out", int'(ena_out), 0, 0);
    check("mid rst rdy_out", int'(rdy_out), 1, 0);
    @(posedge clk);
    #1;
    v = '{default: 100};
    model(v, X);
    tl = '{default: 1};
    X[0] = 283;
    tl[0] = 0;
    push_vec(X, tl, 4);
    send_vec(v, 0, 8);
    wait_drain();

    // Reset while a coefficient is waiting downstream
    rdy_in = 1'b0;
    v = '{300, -200, 100, 0, 50, -50, 400, -400};
    send_vec(v, 0, 8);
    wait_ena(seen);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("flight rst ena_out", int'(ena_out), 0, 0);
    check("flight rst rdy_out", int'(rdy_out), 1, 0);
    check("flight rst S_out", int'(S_out), 0, 0);
    @(posedge clk);
    #1;
    rdy_in = 1'b1;

    // Three ramps back to back
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 8; i++) v[i] = 100 * (b + 1) + i;
      model(v, X);
      tl = '{default: 1};
      push_vec(X, tl, 10 + b);
    end
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 8; i++) v[i] = 100 * (b + 1) + i;
      send_vec(v, 0, 8);
    end
    wait_drain();

    // Random vectors, input gaps and downstream stalls
    bp_rand = 1'b1;
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 8; i++)
        v[i] = int'($urandom_range(0, 1400)) - 700;
      model(v, X);
      tl = '{default: 1};
      push_vec(X, tl, 20 + r);
      send_vec(v, 3, 8);
    end
    wait_drain();
    bp_rand = 1'b0;
    rdy_in  = 1'b1;

    check("scoreboard empty", sbq.size(), 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
